// File: rtl/reg_wb_arbiter_pkg.sv
// ============================================================================
// reg_wb_arbiter_pkg : shared FSM encoding and constants for reg_wb_arbiter
// Revision 1.0
// ============================================================================
`default_nettype none

package reg_wb_arbiter_pkg;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  localparam int NREQ     = 3;
  localparam int LAST_REG = 31;

  function automatic logic [1:0] next_ptr(input logic [1:0] idx);
    return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/reg_wb_arbiter_rr_pick3.sv
// ============================================================================
// rr_pick3 : three-way round-robin selector, priority ptr, ptr+1, ptr+2 mod 3
// Revision 1.0
// ============================================================================
`default_nettype none

module rr_pick3
  import reg_wb_arbiter_pkg::*;
(
  input  logic [NREQ-1:0] valid,
  input  logic [1:0]      ptr,
  output logic [NREQ-1:0] grant,
  output logic [1:0]      idx
);

  logic found;
  int   cand;

  always_comb begin
    grant = '0;
    idx   = 2'd0;
    found = 1'b0;
    cand  = 0;
    for (int i = 0; i < NREQ; i++) begin
      cand = (int'(ptr) + i) % NREQ;
      if (!found && valid[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = 2'(cand);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/reg_wb_arbiter.sv
// ============================================================================
// reg_wb_arbiter : clears r1..r31 after reset, then round-robin arbitrates
// three write requesters onto one register-file write port.
// Optional bypass outputs with `define REG_WB_BYPASS_EN.  Revision 1.0
// ============================================================================
`default_nettype none

module reg_wb_arbiter
  import reg_wb_arbiter_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0_valid,
  input  logic [AW-1:0] req0_wn,
  input  logic [DW-1:0] req0_wd,
  output logic          req0_ready,
  input  logic          req1_valid,
  input  logic [AW-1:0] req1_wn,
  input  logic [DW-1:0] req1_wd,
  output logic          req1_ready,
  input  logic          req2_valid,
  input  logic [AW-1:0] req2_wn,
  input  logic [DW-1:0] req2_wd,
  output logic          req2_ready,
  output logic          RegWrite,
  output logic [AW-1:0] WN,
  output logic [DW-1:0] WD,
  input  logic [AW-1:0] RN1,
  input  logic [AW-1:0] RN2,
  output logic          hazard1,
  output logic          hazard2,
  output logic          init_done
`ifdef REG_WB_BYPASS_EN
  ,
  output logic [DW-1:0] bp1_data,
  output logic [DW-1:0] bp2_data
`endif
);

  state_t          state;
  logic [AW-1:0]   cnt;
  logic [1:0]      ptr;
  logic [NREQ-1:0] valid;
  logic [NREQ-1:0] grant;
  logic [1:0]      win;
  logic            run;
  logic            xfer;
  logic [AW-1:0]   sel_wn;
  logic [DW-1:0]   sel_wd;

  assign valid = {req2_valid, req1_valid, req0_valid};
  assign run   = (state == RUN);

  rr_pick3 u_pick (
    .valid (valid),
    .ptr   (ptr),
    .grant (grant),
    .idx   (win)
  );

  assign req0_ready = run & grant[0];
  assign req1_ready = run & grant[1];
  assign req2_ready = run & grant[2];
  assign xfer       = run & (|valid);

  always_comb begin
    sel_wn = req0_wn;
    sel_wd = req0_wd;
    case (win)
      2'd1: begin
        sel_wn = req1_wn;
        sel_wd = req1_wd;
      end
      2'd2: begin
        sel_wn = req2_wn;
        sel_wd = req2_wd;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= CLEAR;
      cnt       <= AW'(1);
      ptr       <= 2'd0;
      RegWrite  <= 1'b0;
      WN        <= '0;
      WD        <= '0;
      init_done <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          RegWrite <= 1'b1;
          WN       <= cnt;
          WD       <= '0;
          if (cnt == AW'(LAST_REG)) begin
            state     <= RUN;
            init_done <= 1'b1;
          end else begin
            cnt <= cnt + AW'(1);
          end
        end
        RUN: begin
          RegWrite <= 1'b0;
          if (xfer) begin
            ptr <= next_ptr(win);
            // r0 is hardwired: accept the request but suppress the write
            if (sel_wn != '0) begin
              RegWrite <= 1'b1;
              WN       <= sel_wn;
              WD       <= sel_wd;
            end
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

  assign hazard1 = run & RegWrite & (WN == RN1) & (RN1 != '0);
  assign hazard2 = run & RegWrite & (WN == RN2) & (RN2 != '0);

`ifdef REG_WB_BYPASS_EN
  assign bp1_data = hazard1 ? WD : '0;
  assign bp2_data = hazard2 ? WD : '0;
`endif

endmodule

`default_nettype wire

// File: doc/reg_wb_arbiter.md
REG_WB_ARBITER -- requirements
Module: reg_wb_arbiter

Interface
REQ-001 The block SHALL have one clock, clk, and a synchronous active-high reset, reset; all state SHALL change only on posedge clk.
REQ-002 Parameters SHALL be:
- DW, 32, data width.
- AW, 5, register-number width.
REQ-003 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, clock.
- reset, in, 1, synchronous active-high reset.
- reqN_valid, in, 1, requester N (N=0..2) has a write pending.
- reqN_wn, in, AW, requester N destination register number.
- reqN_wd, in, DW, requester N write data.
- reqN_ready, out, 1, requester N is granted this cycle.
- RegWrite, out, 1, register-file write enable.
- WN, out, AW, register-file write number.
- WD, out, DW, register-file write data.
- RN1, in, AW, read port 1 register number.
- RN2, in, AW, read port 2 register number.
- hazard1, out, 1, a write to RN1 is in flight.
- hazard2, out, 1, a write to RN2 is in flight.
- init_done, out, 1, clearing sequence is complete.

Function
REQ-004 The block SHALL use a two-state FSM, CLEAR and RUN; reset SHALL force CLEAR with clear counter cnt=1.
REQ-005 In CLEAR the block SHALL drive one write per cycle of RegWrite=1, WN=cnt, WD=0, with cnt counting 1..31; after cnt=31 is issued it SHALL go to RUN; CLEAR SHALL last exactly 31 cycles.
REQ-006 In CLEAR all reqN_ready SHALL be 0 and init_done SHALL be 0; in RUN init_done SHALL be 1.
REQ-007 In RUN the block SHALL grant at most one requester per cycle by round-robin, with a 2-bit pointer ptr (reset 0) giving priority order ptr, ptr+1, ptr+2 mod 3.
REQ-008 reqN_ready SHALL be combinational: 1 only for the selected valid requester and only in RUN; a transfer SHALL occur when valid and ready are both 1.
REQ-009 After a transfer from requester k, ptr SHALL become (k+1) mod 3; with no transfer, ptr SHALL hold.
REQ-010 RegWrite/WN/WD SHALL be registered: a transfer in cycle t SHALL produce RegWrite=1 with that WN/WD in cycle t+1, for exactly one cycle.
REQ-011 When no transfer occurs, RegWrite SHALL be 0 in the next cycle and WN/WD SHALL hold their previous values.
REQ-012 A transfer with reqN_wn=0 SHALL be accepted and advance ptr, but SHALL produce RegWrite=0.
REQ-013 hazard1 SHALL equal RegWrite && (WN==RN1) && (RN1!=0), combinationally; hazard2 SHALL be the same for RN2.
REQ-014 hazard1 and hazard2 SHALL be forced to 0 in CLEAR.
REQ-015 A requester SHALL hold valid, wn and wd stable until its transfer; the block SHALL NOT buffer ungranted requests.

Reset
REQ-016 Reset SHALL set: state=CLEAR, cnt=1, ptr=0, RegWrite=0, WN=0, WD=0, init_done=0.
REQ-017 Reset asserted mid-CLEAR or mid-RUN SHALL abort the current activity and restart CLEAR from cnt=1 on the cycle after reset deasserts.
REQ-018 A request accepted in the cycle reset is asserted SHALL be discarded.

Configuration
REQ-019 With REG_WB_BYPASS_EN defined, the block SHALL add outputs bp1_data and bp2_data (DW bits each), equal to WD whenever hazard1 or hazard2 respectively is 1, else 0.
REQ-020 With REG_WB_BYPASS_EN undefined, the bp1_data and bp2_data ports and their logic SHALL be absent.

Structure
REQ-021 A shared package SHALL hold the FSM state encoding (CLEAR, RUN), the constant NREQ=3 and the constant LAST_REG=31.
REQ-022 The round-robin selector SHALL be one sub-module, rr_pick3, taking valid[2:0] and ptr and returning a one-hot grant and the winner index.

Verification
REQ-023 The bench SHALL cover at least these directed scenarios:
- Reset then idle: RegWrite=1 for 31 cycles with WN=1..31 and WD=0; init_done=1 on cycle 32; all ready=0 throughout CLEAR.
- RUN with all three valid, wn=5/6/7: grants go 0,1,2,0 on consecutive cycles; WN shows 5,6,7,5, each one cycle after its grant.
- req1 only, wn=0, wd=0xDEAD: ready1=1 and ptr becomes 2, but RegWrite stays 0 next cycle.
- req2 writes wn=9 with RN1=9, RN2=0: the next cycle shows hazard1=1 and hazard2=0; with REG_WB_BYPASS_EN, bp1_data=wd.
- Reset pulsed at CLEAR cnt=17: the sequence restarts at WN=1, and init_done stays 0 for 31 more cycles.
- Reset pulsed during a RUN transfer: no RegWrite follows, and CLEAR restarts.
